pipe_writeback: RTL and testbench

PIPE_WRITEBACK -- requirements
Module: pipe_writeback

---
 rtl/y86_pkg.sv | 56 +++++
 rtl/pipe_w_reg.sv | 37 +++
 rtl/pipe_writeback.sv | 123 ++++++++++++
 tb/tb_pipe_writeback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 constants and the W pipeline register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] c_IHALT   = 4'h0;
    localparam logic [3:0] c_INOP    = 4'h1;
    localparam logic [3:0] c_IRRMOVQ = 4'h2;
    localparam logic [3:0] c_IIRMOVQ = 4'h3;
    localparam logic [3:0] c_IRMMOVQ = 4'h4;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_IJXX    = 4'h7;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    // Status encodings
    localparam logic [2:0] c_SAOK = 3'd1;
    localparam logic [2:0] c_SHLT = 3'd2;
    localparam logic [2:0] c_SADR = 3'd3;
    localparam logic [2:0] c_SINS = 3'd4;

    // Register identifiers
    localparam logic [3:0] c_RNONE = 4'hF;
    localparam logic [3:0] c_RRSP  = 4'h4;

    // W pipeline register contents
    typedef struct packed {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic        valid;
    } w_reg_t;

    // Bubble: a nop that writes nothing and never retires
    localparam w_reg_t c_W_BUBBLE = '{
        icode : c_INOP,
        stat  : c_SAOK,
        valE  : 64'd0,
        valM  : 64'd0,
        dstE  : c_RNONE,
        dstM  : c_RNONE,
        valid : 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/pipe_w_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_w_reg
// Description : W pipeline register with stall, bubble and freeze controls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_w_reg
    import y86_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   bubble,
    input  logic   freeze,
    input  w_reg_t d,
    output w_reg_t q
);

    w_reg_t r_w;

    // Capture the memory stage; stall and freeze hold, bubble inserts a nop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w <= c_W_BUBBLE;
        end else if (stall || freeze) begin
            r_w <= r_w;
        end else if (bubble) begin
            r_w <= c_W_BUBBLE;
        end else begin
            r_w <= d;
        end
    end

    assign q = r_w;

endmodule
`default_nettype wire

// File: rtl/pipe_writeback.sv
`default_nettype none
// ============================================================================
// Module      : pipe_writeback
// Description : Y86-64 write-back stage: W register, register-file write
//               enables, RUN/HALT status machine and retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_writeback
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  m_icode,
    input  logic [2:0]  m_stat,
    input  logic [63:0] m_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  m_dstE,
    input  logic [3:0]  m_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic        weE,
    output logic [3:0]  dstE,
    output logic [63:0] valE,
    output logic        weM,
    output logic [3:0]  dstM,
    output logic [63:0] valM,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    w_reg_t      w_m_in;
    w_reg_t      w_w;
    logic [0:0]  r_state;
    logic [2:0]  r_halt_stat;
    logic [31:0] r_retired;
    logic        w_run;
    logic        w_fault;
    logic        w_ok;
    logic        w_freeze;
    logic        w_retire;
    logic        w_unused_icode;

    assign w_m_in = '{
        icode : m_icode,
        stat  : m_stat,
        valE  : m_valE,
        valM  : m_valM,
        dstE  : m_dstE,
        dstM  : m_dstM,
        valid : 1'b1
    };

    // A faulting instruction stays in W so the halt state reflects it
    assign w_run    = (r_state == c_ST_RUN);
    assign w_fault  = w_w.valid && (w_w.stat != c_SAOK);
    assign w_ok     = w_w.valid && (w_w.stat == c_SAOK) && w_run;
    assign w_freeze = !w_run || w_fault;

    pipe_w_reg u_w_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (W_stall),
        .bubble (W_bubble),
        .freeze (w_freeze),
        .d      (w_m_in),
        .q      (w_w)
    );

    assign dstE = w_w.dstE;
    assign dstM = w_w.dstM;
    assign valE = w_w.valE;
    assign valM = w_w.valM;

    // Same destination on both ports: the M port wins (popq %rsp)
    assign weE = w_ok && (w_w.dstE != c_RNONE) && (w_w.dstE != w_w.dstM);
    assign weM = w_ok && (w_w.dstM != c_RNONE);

    // A stalled instruction retires only on the edge it leaves W
    assign w_retire = w_ok && !W_stall;

    // RUN/HALT machine; latches the faulting status on the transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_RUN;
            r_halt_stat <= c_SAOK;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_fault) begin
                        r_state     <= c_ST_HALT;
                        r_halt_stat <= w_w.stat;
                    end
                end
                default: begin
                    r_state     <= c_ST_HALT;
                    r_halt_stat <= r_halt_stat;
                end
            endcase
        end
    end

    // Saturating count of retired instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= 32'd0;
        end else if (w_retire && (r_retired != 32'hFFFF_FFFF)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign stat    = w_run ? w_w.stat : r_halt_stat;
    assign halted  = (r_state == c_ST_HALT);
    assign retired = r_retired;

    // icode travels with the instruction but does not affect write-back
    assign w_unused_icode = ^w_w.icode;

endmodule
`default_nettype wire

// File: tb/tb_pipe_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_writeback
// Description : Directed self-checking bench for pipe_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_writeback;

    logic        clk;
    logic        rst_n;
    logic [3:0]  m_icode;
    logic [2:0]  m_stat;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic        W_stall;
    logic        W_bubble;
    logic        weE;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic        weM;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    int n_tests;
    int n_fail;

    pipe_writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_icode  (m_icode),
        .m_stat   (m_stat),
        .m_valE   (m_valE),
        .m_valM   (m_valM),
        .m_dstE   (m_dstE),
        .m_dstM   (m_dstM),
        .W_stall  (W_stall),
        .W_bubble (W_bubble),
        .weE      (weE),
        .dstE     (dstE),
        .valE     (valE),
        .weM      (weM),
        .dstM     (dstM),
        .valM     (valM),
        .stat     (stat),
        .halted   (halted),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [2:0] st,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        m_icode  = ic;
        m_stat   = st;
        m_valE   = ve;
        m_valM   = vm;
        m_dstE   = de;
        m_dstM   = dm;
        W_bubble = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (weE !== 1'b0)   begin n_fail++; $display("FAIL reset_weE got %h exp 0", weE); end
        n_tests++; if (weM !== 1'b0)   begin n_fail++; $display("FAIL reset_weM got %h exp 0", weM); end
        n_tests++; if (stat !== 3'd1)  begin n_fail++; $display("FAIL reset_stat got %h exp 1", stat); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %h exp 0", halted); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %h exp 0", retired); end
        n_tests++; if (dstE !== 4'hF || dstM !== 4'hF) begin n_fail++; $display("FAIL reset_dst got %h/%h exp F/F", dstE, dstM); end
        n_tests++; if (valE !== 64'd0 || valM !== 64'd0) begin n_fail++; $display("FAIL reset_val got %h/%h exp 0/0", valE, valM); end
    endtask

    task automatic test_irmovq();
        drive(4'h3, 3'd1, 64'h10, 64'h0, 4'h2, 4'hF);
        tick();
        W_bubble = 1'b1;
        n_tests++; if (weE !== 1'b1)   begin n_fail++; $display("FAIL irmovq_weE got %h exp 1", weE); end
        n_tests++; if (dstE !== 4'h2)  begin n_fail++; $display("FAIL irmovq_dstE got %h exp 2", dstE); end
        n_tests++; if (valE !== 64'h10) begin n_fail++; $display("FAIL irmovq_valE got %h exp 10", valE); end
        n_tests++; if (weM !== 1'b0)   begin n_fail++; $display("FAIL irmovq_weM got %h exp 0", weM); end
        tick();
        n_tests++; if (retired !== 32'd1) begin n_fail++; $display("FAIL irmovq_retired got %h exp 1", retired); end
        n_tests++; if (weE !== 1'b0)   begin n_fail++; $display("FAIL irmovq_after_weE got %h exp 0", weE); end
    endtask

    task automatic test_popq_rsp();
        drive(4'hB, 3'd1, 64'h108, 64'h55, 4'h4, 4'h4);
        tick();
        W_bubble = 1'b1;
        n_tests++; if (weM !== 1'b1)   begin n_fail++; $display("FAIL popq_weM got %h exp 1", weM); end
        n_tests++; if (valM !== 64'h55) begin n_fail++; $display("FAIL popq_valM got %h exp 55", valM); end
        n_tests++; if (dstM !== 4'h4)  begin n_fail++; $display("FAIL popq_dstM got %h exp 4", dstM); end
        n_tests++; if (weE !== 1'b0)   begin n_fail++; $display("FAIL popq_weE got %h exp 0", weE); end
        tick();
        n_tests++; if (retired !== 32'd2) begin n_fail++; $display("FAIL popq_retired got %h exp 2", retired); end
    endtask

    task automatic test_back_to_back();
        drive(4'h6, 3'd1, 64'h77, 64'h0, 4'h7, 4'hF);
        tick();
        n_tests++; if (weE !== 1'b1 || dstE !== 4'h7 || valE !== 64'h77) begin n_fail++; $display("FAIL b2b_opq got weE=%h dstE=%h valE=%h exp 1/7/77", weE, dstE, valE); end
        drive(4'h5, 3'd1, 64'h0, 64'hAA, 4'hF, 4'h3);
        tick();
        W_bubble = 1'b1;
        n_tests++; if (weM !== 1'b1 || dstM !== 4'h3 || valM !== 64'hAA) begin n_fail++; $display("FAIL b2b_mrmovq got weM=%h dstM=%h valM=%h exp 1/3/AA", weM, dstM, valM); end
        n_tests++; if (weE !== 1'b0)   begin n_fail++; $display("FAIL b2b_mrmovq_weE got %h exp 0", weE); end
        n_tests++; if (retired !== 32'd3) begin n_fail++; $display("FAIL b2b_mid_retired got %h exp 3", retired); end
        tick();
        n_tests++; if (retired !== 32'd4) begin n_fail++; $display("FAIL b2b_retired got %h exp 4", retired); end
    endtask

    task automatic test_stall();
        drive(4'h6, 3'd1, 64'h33, 64'h0, 4'h3, 4'hF);
        tick();
        W_stall = 1'b1;
        drive(4'h6, 3'd1, 64'h55, 64'h0, 4'h5, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (weE !== 1'b1 || dstE !== 4'h3 || valE !== 64'h33) begin n_fail++; $display("FAIL stall_hold[%0d] got weE=%h dstE=%h valE=%h exp 1/3/33", i, weE, dstE, valE); end
            n_tests++; if (retired !== 32'd4) begin n_fail++; $display("FAIL stall_retired[%0d] got %h exp 4", i, retired); end
        end
        W_bubble = 1'b1;
        tick();
        n_tests++; if (dstE !== 4'h3 || valE !== 64'h33) begin n_fail++; $display("FAIL stall_bubble_prio got dstE=%h valE=%h exp 3/33", dstE, valE); end
        n_tests++; if (retired !== 32'd4) begin n_fail++; $display("FAIL stall_bubble_retired got %h exp 4", retired); end
        W_stall = 1'b0;
        tick();
        n_tests++; if (retired !== 32'd5) begin n_fail++; $display("FAIL stall_release_retired got %h exp 5", retired); end
        n_tests++; if (weE !== 1'b0 || dstE !== 4'hF) begin n_fail++; $display("FAIL stall_release_w got weE=%h dstE=%h exp 0/F", weE, dstE); end
    endtask

    task automatic test_halt();
        drive(4'h0, 3'd2, 64'h0, 64'h0, 4'hF, 4'hF);
        tick();
        n_tests++; if (weE !== 1'b0 || weM !== 1'b0) begin n_fail++; $display("FAIL halt_we got %h/%h exp 0/0", weE, weM); end
        n_tests++; if (halted !== 1'b0 || stat !== 3'd2) begin n_fail++; $display("FAIL halt_inW got halted=%h stat=%h exp 0/2", halted, stat); end
        drive(4'h3, 3'd1, 64'h20, 64'h0, 4'h2, 4'hF);
        tick();
        n_tests++; if (halted !== 1'b1 || stat !== 3'd2) begin n_fail++; $display("FAIL halt_state got halted=%h stat=%h exp 1/2", halted, stat); end
        n_tests++; if (weE !== 1'b0 || weM !== 1'b0) begin n_fail++; $display("FAIL halt_ignore_we got %h/%h exp 0/0", weE, weM); end
        tick();
        n_tests++; if (retired !== 32'd5) begin n_fail++; $display("FAIL halt_retired got %h exp 5", retired); end
        n_tests++; if (halted !== 1'b1 || weE !== 1'b0) begin n_fail++; $display("FAIL halt_absorb got halted=%h weE=%h exp 1/0", halted, weE); end
        // Asynchronous reset away from any edge
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (halted !== 1'b0 || stat !== 3'd1 || retired !== 32'd0) begin n_fail++; $display("FAIL halt_async_reset got halted=%h stat=%h retired=%h exp 0/1/0", halted, stat, retired); end
        W_bubble = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_adr_fault();
        drive(4'h5, 3'd3, 64'h0, 64'h99, 4'hF, 4'h1);
        tick();
        W_bubble = 1'b1;
        n_tests++; if (weM !== 1'b0)  begin n_fail++; $display("FAIL adr_weM got %h exp 0", weM); end
        n_tests++; if (stat !== 3'd3) begin n_fail++; $display("FAIL adr_stat_inW got %h exp 3", stat); end
        tick();
        n_tests++; if (halted !== 1'b1 || stat !== 3'd3) begin n_fail++; $display("FAIL adr_halt got halted=%h stat=%h exp 1/3", halted, stat); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL adr_retired got %h exp 0", retired); end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        force dut.r_retired = 32'hFFFF_FFFE;
        #1;
        release dut.r_retired;
        drive(4'h6, 3'd1, 64'h1, 64'h0, 4'h2, 4'hF);
        tick();
        tick();
        n_tests++; if (retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_step got %h exp FFFFFFFF", retired); end
        tick();
        W_bubble = 1'b1;
        tick();
        n_tests++; if (retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold got %h exp FFFFFFFF", retired); end
        // Reset mid-stream discards a valid W with a pending write
        drive(4'h6, 3'd1, 64'h66, 64'h0, 4'h6, 4'hF);
        tick();
        n_tests++; if (weE !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_weE got %h exp 1", weE); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (weE !== 1'b0 || weM !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %h/%h exp 0/0", weE, weM); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL midrst_retired got %h exp 0", retired); end
        n_tests++; if (dstE !== 4'hF || valE !== 64'd0) begin n_fail++; $display("FAIL midrst_w got dstE=%h valE=%h exp F/0", dstE, valE); end
        n_tests++; if (stat !== 3'd1 || halted !== 1'b0) begin n_fail++; $display("FAIL midrst_stat got stat=%h halted=%h exp 1/0", stat, halted); end
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        W_stall  = 1'b0;
        W_bubble = 1'b1;
        m_icode  = 4'h1;
        m_stat   = 3'd1;
        m_valE   = 64'd0;
        m_valM   = 64'd0;
        m_dstE   = 4'hF;
        m_dstM   = 4'hF;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_irmovq();
        test_popq_rsp();
        test_back_to_back();
        test_stall();
        test_halt();
        test_adr_fault();
        test_saturation();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
